// File: rtl/fir_normalizer.sv
`timescale 1ns/1ps
// Normalises a filter tap sum by a divisor with a WIDTH-cycle restoring divider
// and queues quotients in a DEPTH-entry FIFO. Define FIR_NORMALIZER_ROUND_EN for round-to-nearest.
module fir_normalizer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             div_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_zero;
  logic             r_div_zero;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // r_quot starts as the dividend; its MSB shifts into the remainder each step
  // while the new quotient bit enters at the LSB.
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_next;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_push_data;

  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_ge       = (w_shift >= {2'b00, r_divisor});
  assign w_rem_next = w_ge ? (WIDTH+1)'(w_shift - {2'b00, r_divisor}) : w_shift[WIDTH:0];

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same edge frees the slot, so a full FIFO can still take the push.
  assign w_push  = (r_state == WRITE) && (!w_full || w_pop);

`ifdef FIR_NORMALIZER_ROUND_EN
  logic w_round_up;
  assign w_round_up = ({r_rem, 1'b0} >= {2'b00, r_divisor});
  assign w_q_final  = (w_round_up && (r_quot != '1)) ? r_quot + 1'b1 : r_quot;
`else
  assign w_q_final  = r_quot;
`endif

  assign w_push_data = r_zero ? '1 : w_q_final;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_bit_cnt  <= '0;
      r_zero     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_quot     <= in_data;
            r_divisor  <= divisor;
            r_rem      <= '0;
            r_bit_cnt  <= '0;
            r_zero     <= (divisor == '0);
            if (divisor == '0) r_div_zero <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          r_rem     <= w_rem_next;
          r_quot    <= {r_quot[WIDTH-2:0], w_ge};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == CW'(WIDTH - 1)) r_state <= WRITE;
        end
        WRITE: begin
          if (w_push) begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset; out_data is gated to zero while empty instead.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign div_zero  = r_div_zero;

endmodule

// File: doc/fir_normalizer.md
FIR_NORMALIZER -- requirements
Module: fir_normalizer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the data width of filter-sum input, divisor and quotient.
REQ-002 The block SHALL take parameter DEPTH, default 4, the output FIFO depth in entries (power of two, at least 2).
REQ-003 The block SHALL provide port clk  input  1  clock, all state updated on rising edge.
REQ-004 The block SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL provide port in_valid  input  1  the filter sum on in_data is valid.
REQ-006 The block SHALL provide port in_ready  output  1  the block accepts a sample this cycle.
REQ-007 The block SHALL provide port in_data  input  WIDTH  the weighted tap sum from the averaging stage.
REQ-008 The block SHALL provide port divisor  input  WIDTH  the normalisation divisor, sampled on accept.
REQ-009 The block SHALL provide port out_valid  output  1  the FIFO head is valid.
REQ-010 The block SHALL provide port out_ready  input  1  the consumer takes the FIFO head.
REQ-011 The block SHALL provide port out_data  output  WIDTH  the normalised sample at the FIFO head.
REQ-012 The block SHALL provide port div_zero  output  1  sticky flag, set when a zero divisor is seen.

Function
REQ-013 The FSM SHALL have states IDLE, DIV and WRITE, with in_ready = 1 only in IDLE.
REQ-014 An accept (in_valid & in_ready at edge k) SHALL latch in_data and divisor, clear the remainder, and move to DIV.
REQ-015 DIV SHALL run a restoring shift-subtract division, one quotient bit per edge, MSB first, for exactly WIDTH edges (k+1..k+WIDTH), then move to WRITE.
REQ-016 The remainder register SHALL be WIDTH+1 bits, and the quotient SHALL be the exact unsigned floor(in_data/divisor).
REQ-017 In WRITE with the FIFO not full, the quotient SHALL be pushed at edge k+WIDTH+1, and the FSM SHALL return to IDLE.
REQ-018 Back-to-back accept latency SHALL be WIDTH+2 edges; out_valid SHALL rise after edge k+WIDTH+1 when the FIFO was empty.
REQ-019 In WRITE with the FIFO full, the FSM SHALL hold WRITE with in_ready = 0 until a pop frees an entry.
REQ-020 A simultaneous pop and push on a full FIFO SHALL be allowed in the same edge, and occupancy SHALL remain full.
REQ-021 If divisor = 0, the quotient SHALL be forced to all ones, and div_zero SHALL be set and hold until reset.
REQ-022 out_data SHALL always show the FIFO head, and a pop SHALL occur on out_valid & out_ready.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits SHALL distinguish full from empty.
REQ-024 Samples SHALL leave the FIFO in acceptance order, with none dropped or duplicated.

Reset
REQ-025 Reset SHALL drive FSM = IDLE, FIFO empty, out_valid = 0, out_data = 0, div_zero = 0, and clear the quotient and remainder.
REQ-026 Reset asserted mid-DIV or mid-WRITE SHALL abort the operation with no push, and the first accept after release SHALL behave as from power-up.

Configuration
REQ-027 With macro FIR_NORMALIZER_ROUND_EN defined, the WRITE push SHALL add 1 to the quotient when 2*remainder >= divisor, saturating at all ones, with no added latency.
REQ-028 Without FIR_NORMALIZER_ROUND_EN, the quotient SHALL be pushed truncated, and no rounding logic SHALL be present.

Verification
REQ-029 The bench SHALL apply reset, then in_data = 40, divisor = 5, out_ready = 1 and check out_data = 8 after exactly 9 edges, with in_ready low for edges 1..9.
REQ-030 The bench SHALL apply in_data = 43, divisor = 5 and check out_data = 8 without the macro, and 9 with FIR_NORMALIZER_ROUND_EN.
REQ-031 The bench SHALL apply in_data = 255, divisor = 0 and check out_data = 255 with div_zero = 1 staying high across later valid samples.
REQ-032 The bench SHALL hold out_ready = 0, offer inputs 10, 20, 30, 40, 50 with divisor = 1, and check that 4 are stored, the FSM stalls in WRITE with in_ready = 0, and raising out_ready yields 10, 20, 30, 40, 50 in order.
REQ-033 The bench SHALL assert reset 4 edges into a DIV on in_data = 100, then offer 25/5, and check that only out_data = 5 ever appears.
REQ-034 The bench SHALL stream 20 samples from the averaging stage with divisor = 5 and match each output against the floor of the golden sum/5.
